// File: rtl/datapath_pkg.sv
// datapath_pkg: shared op encoding, sequencer states and datapath sizes.
package datapath_pkg;
   localparam int NUM_REGS = 3;
   localparam int DATA_W = 8;
   typedef enum logic [1:0] {OP_ADD = 2'b00, OP_ADC = 2'b01, OP_MUL = 2'b10, OP_CLR = 2'b11} op_e;
   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_EXEC, S_WRITE, S_DONE} state_e;
endpackage

// File: rtl/wait_counter.sv
// wait_counter: loadable down-counter flagging its final EXEC cycle.
module wait_counter #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic [W-1:0] val_i,
   input  logic         dec_i,
   output logic         last_o
);
   logic [W-1:0] cnt_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else if (load_i) cnt_q <= val_i;
      else if (dec_i && cnt_q != '0) cnt_q <= cnt_q - 1'b1;
   end
   assign last_o = cnt_q == W'(1);
endmodule

// File: rtl/datapath_sequencer.sv
// datapath_sequencer: steps the register/ALU datapath through one dst <- src OP imm command.
module datapath_sequencer
   import datapath_pkg::*;
#(
   parameter int ADD_WAIT = 1,
   parameter int MUL_WAIT = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cmd_valid_i,
   output logic                cmd_ready_o,
   input  logic [1:0]          cmd_op_i,
   input  logic [1:0]          cmd_src_i,
   input  logic [1:0]          cmd_dst_i,
   input  logic [DATA_W-1:0]   cmd_imm_i,
   input  logic                carry_out_i,
   output logic [NUM_REGS-1:0] src_oe_o,
   output logic                add_oe_o,
   output logic                mul_oe_o,
   output logic [NUM_REGS-1:0] reg_load_o,
   output logic                reg_clear_o,
   output logic [DATA_W-1:0]   imm_out_o,
   output logic                carry_in_o,
   output logic                flag_c_o,
   output logic                done_o,
   output logic                err_o
);
   localparam int MAXW = ADD_WAIT > MUL_WAIT ? ADD_WAIT : MUL_WAIT;
   localparam int CW = $clog2(MAXW + 1);
   state_e state_q, state_d;
   op_e op_q, op_d;
   logic [1:0] src_q, src_d, dst_q, dst_d;
   logic [DATA_W-1:0] imm_q, imm_d;
   logic bad_q, bad_d, flag_q, flag_d, cnt_load, cnt_last, act;
   logic [NUM_REGS-1:0] src_oe_q, reg_load_q;
   logic [DATA_W-1:0] imm_out_q;
   logic ready_q, add_oe_q, mul_oe_q, clear_q, carry_in_q, done_q, err_q;
   wait_counter #(.W(CW)) u_cnt (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (cnt_load),
      .val_i  (op_e'(cmd_op_i) == OP_MUL ? CW'(MUL_WAIT) : CW'(ADD_WAIT)),
      .dec_i  (state_q == S_EXEC),
      .last_o (cnt_last)
   );
   always_comb begin
      state_d = state_q;
      op_d = op_q;
      src_d = src_q;
      dst_d = dst_q;
      imm_d = imm_q;
      bad_d = bad_q;
      flag_d = flag_q;
      cnt_load = 1'b0;
      case (state_q)
         S_IDLE: if (cmd_valid_i) begin
            op_d = op_e'(cmd_op_i);
            src_d = cmd_src_i;
            dst_d = cmd_dst_i;
            imm_d = cmd_imm_i;
            bad_d = op_d != OP_CLR && (cmd_src_i == 2'd3 || cmd_dst_i == 2'd3);
            state_d = op_d == OP_CLR ? S_CLEAR : bad_d ? S_DONE : S_EXEC;
            cnt_load = state_d == S_EXEC;
         end
         S_CLEAR: state_d = S_DONE;
         S_EXEC:  state_d = cnt_last ? S_WRITE : S_EXEC;
         S_WRITE: begin
            state_d = S_DONE;
            flag_d = op_q == OP_MUL ? flag_q : carry_out_i;
         end
         default: state_d = S_IDLE;
      endcase
   end
   // Outputs are registered from the next state so they line up with the state they belong to.
   assign act = state_d == S_EXEC || state_d == S_WRITE;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q <= OP_ADD;
         src_q <= '0;
         dst_q <= '0;
         imm_q <= '0;
         bad_q <= 1'b0;
         flag_q <= 1'b0;
         ready_q <= 1'b1;
         src_oe_q <= '0;
         add_oe_q <= 1'b0;
         mul_oe_q <= 1'b0;
         reg_load_q <= '0;
         clear_q <= 1'b0;
         imm_out_q <= '0;
         carry_in_q <= 1'b0;
         done_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q <= op_d;
         src_q <= src_d;
         dst_q <= dst_d;
         imm_q <= imm_d;
         bad_q <= bad_d;
         flag_q <= flag_d;
         ready_q <= state_d == S_IDLE;
         src_oe_q <= act ? NUM_REGS'(1) << src_d : '0;
         add_oe_q <= act && op_d != OP_MUL;
         mul_oe_q <= act && op_d == OP_MUL;
         reg_load_q <= state_d == S_WRITE ? NUM_REGS'(1) << dst_d : '0;
         clear_q <= state_d == S_CLEAR;
         imm_out_q <= act ? imm_d : '0;
         carry_in_q <= act && op_d == OP_ADC && flag_d;
         done_q <= state_d == S_DONE;
         err_q <= state_d == S_DONE && bad_d;
      end
   end
   assign cmd_ready_o = ready_q;
   assign src_oe_o = src_oe_q;
   assign add_oe_o = add_oe_q;
   assign mul_oe_o = mul_oe_q;
   assign reg_load_o = reg_load_q;
   assign reg_clear_o = clear_q;
   assign imm_out_o = imm_out_q;
   assign carry_in_o = carry_in_q;
   assign flag_c_o = flag_q;
   assign done_o = done_q;
   assign err_o = err_q;
endmodule

// File: tb/tb_datapath_sequencer.sv
// tb_datapath_sequencer: directed command sequence with hand-computed strobe expectations.
module tb_datapath_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   logic cmd_valid = 1'b0, carry_out = 1'b0;
   logic [1:0] cmd_op = 2'd0, cmd_src = 2'd0, cmd_dst = 2'd0;
   logic [7:0] cmd_imm = 8'd0, imm_out;
   logic [2:0] src_oe, reg_load;
   logic cmd_ready, add_oe, mul_oe, reg_clear, carry_in, flag_c, done, err;
   int vectors = 0, miscompares = 0;
   always #5 clk = ~clk;
   datapath_sequencer dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
      .cmd_op_i(cmd_op), .cmd_src_i(cmd_src), .cmd_dst_i(cmd_dst), .cmd_imm_i(cmd_imm),
      .carry_out_i(carry_out), .src_oe_o(src_oe), .add_oe_o(add_oe), .mul_oe_o(mul_oe),
      .reg_load_o(reg_load), .reg_clear_o(reg_clear), .imm_out_o(imm_out),
      .carry_in_o(carry_in), .flag_c_o(flag_c), .done_o(done), .err_o(err)
   );
   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst, input logic [7:0] imm);
      cmd_valid = 1'b1;
      cmd_op = op;
      cmd_src = src;
      cmd_dst = dst;
      cmd_imm = imm;
   endtask
   always @(negedge clk) if (rst_n) begin
      chk("inv_src_onehot", 8'($onehot0(src_oe)), 8'd1);
      chk("inv_add_mul", 8'(add_oe & mul_oe), 8'd0);
      chk("inv_load_onehot", 8'($onehot0(reg_load)), 8'd1);
      chk("inv_clear_load", 8'(reg_clear & |reg_load), 8'd0);
   end
   initial begin
      #1 rst_n = 1'b0;
      #3;
      chk("rst_ready", 8'(cmd_ready), 8'd1);
      chk("rst_strobes", {src_oe, reg_load, add_oe, mul_oe}, 8'd0);
      chk("rst_misc", {reg_clear, carry_in, flag_c, done, err}, 8'd0);
      chk("rst_imm", imm_out, 8'd0);
      tick();
      tick();
      rst_n = 1'b1;
      // ADD r1 <- r0 + 5, carry_out high
      send(2'b00, 2'd0, 2'd1, 8'h05);
      carry_out = 1'b1;
      tick();
      cmd_valid = 1'b0;
      chk("add_exec_src", 8'(src_oe), 8'b001);
      chk("add_exec_oe", {add_oe, mul_oe}, 8'b10);
      chk("add_exec_imm", imm_out, 8'h05);
      chk("add_exec_load", 8'(reg_load), 8'd0);
      chk("add_exec_ready", 8'(cmd_ready), 8'd0);
      tick();
      chk("add_write_load", 8'(reg_load), 8'b010);
      chk("add_write_src", 8'(src_oe), 8'b001);
      chk("add_write_done", 8'(done), 8'd0);
      tick();
      chk("add_done", {done, err}, 8'b10);
      chk("add_flag", 8'(flag_c), 8'd1);
      chk("add_done_src", 8'(src_oe), 8'd0);
      tick();
      chk("idle_ready", 8'(cmd_ready), 8'd1);
      // ADC r1 <- r1 + 0xFF + C
      send(2'b01, 2'd1, 2'd1, 8'hFF);
      tick();
      cmd_valid = 1'b0;
      chk("adc_exec_cin", 8'(carry_in), 8'd1);
      chk("adc_exec_src", 8'(src_oe), 8'b010);
      chk("adc_exec_imm", imm_out, 8'hFF);
      carry_out = 1'b0;
      tick();
      chk("adc_write_cin", 8'(carry_in), 8'd1);
      chk("adc_write_load", {src_oe, reg_load}, {2'b00, 3'b010, 3'b010});
      tick();
      chk("adc_done", 8'(done), 8'd1);
      chk("adc_flag", 8'(flag_c), 8'd0);
      chk("adc_done_cin", 8'(carry_in), 8'd0);
      tick();
      // MUL r0 <- r2 * 3
      send(2'b10, 2'd2, 2'd0, 8'h03);
      tick();
      cmd_valid = 1'b0;
      carry_out = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         chk($sformatf("mul_exec%0d_oe", i), {add_oe, mul_oe}, 8'b01);
         chk($sformatf("mul_exec%0d_load", i), 8'(reg_load), 8'd0);
         chk($sformatf("mul_exec%0d_src", i), 8'(src_oe), 8'b100);
         tick();
      end
      chk("mul_write_oe", {add_oe, mul_oe}, 8'b01);
      chk("mul_write_load", 8'(reg_load), 8'b001);
      chk("mul_write_cin", 8'(carry_in), 8'd0);
      tick();
      chk("mul_done", {done, err}, 8'b10);
      chk("mul_flag", 8'(flag_c), 8'd0);
      tick();
      // CLR then illegal ADD
      send(2'b11, 2'd3, 2'd3, 8'h00);
      tick();
      cmd_valid = 1'b0;
      chk("clr_pulse", {reg_clear, done}, 8'b10);
      chk("clr_src", 8'(src_oe), 8'd0);
      tick();
      chk("clr_done", {reg_clear, done, err}, 8'b010);
      tick();
      send(2'b00, 2'd0, 2'd3, 8'h12);
      tick();
      cmd_valid = 1'b0;
      chk("bad_done_err", {done, err}, 8'b11);
      chk("bad_strobes", {src_oe, reg_load, add_oe, mul_oe}, 8'd0);
      chk("bad_imm", imm_out, 8'd0);
      tick();
      chk("bad_ready", 8'(cmd_ready), 8'd1);
      // back-to-back ADDs with valid held; imm changes mid-EXEC
      send(2'b00, 2'd1, 2'd2, 8'h11);
      tick();
      cmd_imm = 8'hAA;
      chk("b2b_exec_imm", imm_out, 8'h11);
      tick();
      chk("b2b_write_imm", imm_out, 8'h11);
      chk("b2b_write_load", 8'(reg_load), 8'b100);
      tick();
      chk("b2b_done", {done, cmd_ready}, 8'b10);
      tick();
      chk("b2b_idle", {cmd_ready, add_oe, done}, 8'b100);
      tick();
      chk("b2b_second_imm", imm_out, 8'hAA);
      chk("b2b_second_oe", {add_oe, cmd_ready}, 8'b10);
      cmd_valid = 1'b0;
      tick();
      tick();
      chk("b2b_second_done", 8'(done), 8'd1);
      chk("b2b_flag", 8'(flag_c), 8'd1);
      tick();
      // reset during MUL EXEC cycle 2
      send(2'b10, 2'd0, 2'd1, 8'h07);
      tick();
      cmd_valid = 1'b0;
      tick();
      chk("abort_pre_oe", 8'(mul_oe), 8'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("abort_strobes", {src_oe, reg_load, add_oe, mul_oe}, 8'd0);
      chk("abort_misc", {reg_clear, carry_in, flag_c, done, err}, 8'd0);
      chk("abort_imm", imm_out, 8'd0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("abort_ready", 8'(cmd_ready), 8'd1);
      for (int i = 0; i < 4; i++) begin
         chk("abort_no_done", {done, reg_load}, 8'd0);
         tick();
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
